// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: command modes, FSM states, count direction.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    MODE_ONESHOT_UP   = 2'd0,
    MODE_ONESHOT_DOWN = 2'd1,
    MODE_RELOAD_UP    = 2'd2,
    MODE_PINGPONG     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    LOAD = 2'd2,
    RUN  = 2'd3
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Control/status bundle between the sequencer (master) and the up/down counter (slave).
interface counter_seq_ctrl_if #(
  parameter int N = 8
);
  logic [N-1:0] cnt_q;
  logic         cnt_max;
  logic         cnt_min;
  logic         cnt_syn_clr;
  logic         cnt_load;
  logic [N-1:0] cnt_d;
  logic         cnt_en;
  logic         cnt_up;

  modport master (
    output cnt_syn_clr, cnt_load, cnt_d, cnt_en, cnt_up,
    input  cnt_q, cnt_max, cnt_min
  );

  modport slave (
    input  cnt_syn_clr, cnt_load, cnt_d, cnt_en, cnt_up,
    output cnt_q, cnt_max, cnt_min
  );
endinterface

// File: rtl/counter_seq_ctrl_tick_prescaler.sv
// Rate divider: tick is high once every div+1 cycles while restart is low.
// restart holds the count at zero so the first tick lands div cycles after release.
module tick_prescaler #(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  input  logic [PW-1:0] div,
  output logic          tick
);

  logic [PW-1:0] count;

  assign tick = (count == div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (restart || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer driving a universal up/down counter: one-shot, auto-reload and ping-pong modes.
// Counter controls are decoded from registered state only; done is a registered one-cycle pulse.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int N  = 8,
  parameter int PW = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic [1:0]          mode,
  input  logic [N-1:0]        preset,
  input  logic [N-1:0]        limit,
  input  logic [PW-1:0]       div,
  counter_seq_ctrl_if.master  cnt_if,
  output logic                busy,
  output logic                done
);

  state_e        state;
  mode_e         mode_r;
  logic [N-1:0]  preset_r;
  logic [N-1:0]  limit_r;
  logic [PW-1:0] div_r;
  logic          dir_r;

  logic tick;
  logic restart;
  logic run;
  logic at_limit;
  logic oneshot;
  logic turn;

  assign restart = (state != RUN);
  assign run     = (state == RUN);

  tick_prescaler #(.PW(PW)) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .div     (div_r),
    .tick    (tick)
  );

  assign at_limit = (cnt_if.cnt_q == limit_r);
  assign oneshot  = (mode_r == MODE_ONESHOT_UP) || (mode_r == MODE_ONESHOT_DOWN);
  // Ping-pong reverses and steps in the same cycle, so the turnaround needs the tick.
  assign turn     = run && tick && (mode_r == MODE_PINGPONG) &&
                    ((dir_r == DIR_UP) ? cnt_if.cnt_max : cnt_if.cnt_min);

  assign busy = (state != IDLE);

  always_comb begin
    cnt_if.cnt_syn_clr = (state == CLR);
    cnt_if.cnt_load    = (state == LOAD) ||
                         (run && tick && (mode_r == MODE_RELOAD_UP) && at_limit);
    cnt_if.cnt_d       = preset_r;
    cnt_if.cnt_en      = run && tick && ((mode_r == MODE_PINGPONG) || !at_limit);
    cnt_if.cnt_up      = 1'b0;
    if (run) begin
      case (mode_r)
        MODE_ONESHOT_DOWN: cnt_if.cnt_up = 1'b0;
        MODE_PINGPONG:     cnt_if.cnt_up = turn ? ~dir_r : dir_r;
        default:           cnt_if.cnt_up = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mode_r   <= MODE_ONESHOT_UP;
      preset_r <= '0;
      limit_r  <= '0;
      div_r    <= '0;
      dir_r    <= DIR_UP;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state <= CLR;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              mode_r   <= mode_e'(mode);
              preset_r <= preset;
              limit_r  <= limit;
              div_r    <= div;
              state    <= LOAD;
            end
          end
          CLR: state <= IDLE;
          LOAD: begin
            if (stop) begin
              state <= IDLE;
            end else begin
              state <= RUN;
              dir_r <= DIR_UP;
            end
          end
          RUN: begin
            if (stop) begin
              state <= IDLE;
            end else if (oneshot) begin
              if (at_limit) begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end else if (mode_r == MODE_RELOAD_UP) begin
              if (tick && at_limit) done <= 1'b1;
            end else if (turn) begin
              dir_r <= (dir_r == DIR_UP) ? DIR_DOWN : DIR_UP;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Control sequencer that sits directly upstream of the team's N-bit universal up/down counter.
- Drives the counter's syn_clr, load, d, en and up inputs, and consumes its q, max and min outputs.
- Provides one-shot up, one-shot down, auto-reload and ping-pong counting at a programmable rate.
- Gives software/top-level a single start/stop/clear command interface instead of raw counter controls.

Parameters:
N, 8, counter width; must match the downstream counter.
PW, 16, prescaler width; sets the maximum rate divider.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin sequence; honoured only in IDLE
stop  in  1  abort sequence; counter holds its value
clear  in  1  request synchronous clear of the counter
mode  in  2  0=ONESHOT_UP, 1=ONESHOT_DOWN, 2=RELOAD_UP, 3=PINGPONG
preset  in  N  start value loaded into the counter
limit  in  N  terminal value for modes 0-2
div  in  PW  rate divider; one count step every div+1 cycles
cnt_q  in  N  counter value
cnt_max  in  1  counter at all-ones
cnt_min  in  1  counter at zero
cnt_syn_clr  out  1  to counter syn_clr
cnt_load  out  1  to counter load
cnt_d  out  N  to counter d
cnt_en  out  1  to counter en
cnt_up  out  1  to counter up
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at terminal/turnaround/reload

Behaviour:
- States: IDLE, CLR, LOAD, RUN.
  - Registered: state, mode_r, preset_r, limit_r, div_r, prescale count, dir_r, done.
- cnt_* outputs are combinational decode of the registered state, the prescaler tick, cnt_q/cnt_max/cnt_min and the latched copies.
  - No combinational path from start/stop/clear/mode/preset/limit/div to any output.
  - No loop exists, because the counter's q is registered.
- Reset: state=IDLE, prescale count=0, dir_r=up, done=0, all cnt_* outputs=0, busy=0.
  - Reset mid-sequence aborts immediately; the counter is reset by its own reset.
- Command priority per cycle: clear > stop > start.
  - clear: next state CLR from any state. CLR lasts 1 cycle with cnt_syn_clr=1, then IDLE.
  - stop in LOAD/RUN: next state IDLE; no done pulse; counter holds.
  - start in IDLE: latch mode/preset/limit/div, next state LOAD. start outside IDLE is ignored.
- LOAD (1 cycle): cnt_load=1, cnt_d=preset_r. Next state RUN, prescale count=0, dir_r=up.
- RUN:
  - tick = (prescale count == div_r).
  - On tick the prescale count returns to 0; otherwise it increments. div=0 gives a tick every cycle.
  - cnt_en is asserted only in cycles where tick=1. cnt_up=1 except ONESHOT_DOWN, or PINGPONG with dir_r=down.
  - ONESHOT_UP/DOWN: term=(cnt_q==limit_r).
    - cnt_en=tick & ~term.
    - When term=1: next state IDLE; done=1 in the following cycle.
    - Counting is modulo 2^N: a limit on the "wrong" side of the preset is reached via wrap-around.
    - preset==limit: done in the first RUN cycle +1, with zero steps.
  - RELOAD_UP: on tick with cnt_q==limit_r, assert cnt_load (cnt_d=preset_r) instead of cnt_en; done=1 next cycle. Stays in RUN.
  - PINGPONG: limit is ignored.
    - On tick with dir_r=up and cnt_max: dir_r<=down, cnt_up=0, cnt_en=1, done next cycle.
    - Symmetric at cnt_min with dir_r=down.
    - The direction reversal and the step happen in the same cycle, with no dwell.
- Tick coinciding with stop: that cycle's cnt_en/cnt_load still issues; IDLE follows.
- At most one of cnt_syn_clr/cnt_load/cnt_en is high in any cycle.
- In IDLE, cnt_d = preset_r.

Decomposition:
- Package counter_seq_pkg holds:
  - mode constants MODE_ONESHOT_UP=0, MODE_ONESHOT_DOWN=1, MODE_RELOAD_UP=2, MODE_PINGPONG=3;
  - state encoding (IDLE, CLR, LOAD, RUN);
  - DIR_UP=1, DIR_DOWN=0.
- One sub-module: tick_prescaler #(PW).
  - Inputs: clk, reset, restart, div.
  - Output: tick.
  - The rest is the FSM.

Test Plan (bench instantiates the universal counter downstream, N=8):
1. ONESHOT_UP, preset=10, limit=13, div=0, start at cycle 0 -> cnt_load in cycle 1; q=10,11,12,13 in cycles 2-5; done=1 and busy=0 in cycle 6; q holds 13.
2. ONESHOT_UP, preset=0, limit=3, div=3 -> cnt_en exactly once every 4 cycles; 3 en pulses total; done 1 cycle after q=3.
3. RELOAD_UP, preset=250, limit=252, div=0 -> q sequence 250,251,252,250,251,252...; done pulses coincide with the cycle after each reload; busy stays 1 until stop.
4. PINGPONG, preset=253, div=0 -> q 253,254,255,254,...,1,0,1...; done after the 255 and the 0 turnarounds; cnt_up flips in the turnaround cycle.
5. ONESHOT_DOWN, preset=2, limit=254 -> q 2,1,0,255,254; done; no further en.
6. Mid-RUN clear with stop+start in the same cycle -> 1 cycle of cnt_syn_clr, q=0, IDLE, no done. Separately, stop -> q frozen, no done. Async reset mid-RUN -> all outputs 0 immediately, busy=0.
